// File: rtl/pulse_interval_fifo_if.sv
// Output stream of the pulse interval FIFO.
// Groups the measured-interval handshake (out_data/out_valid/out_ready) with the
// occupancy (level) and sticky drop flag (overflow).
//   master : driven by pulse_interval_fifo
//   slave  : the consumer, drives out_ready
interface pulse_interval_fifo_if #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LVL_W-1:0] level;
  logic             overflow;

  modport master (
    output out_data,
    output out_valid,
    output level,
    output overflow,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  level,
    input  overflow,
    output out_ready
  );
endinterface

// File: rtl/pulse_interval_fifo.sv
// Pulse interval measurement with a first-word-fall-through result FIFO.
// Rising edges of in_pulse are timestamped by a saturating cycle timer; every
// armed edge pushes the distance (in cycles) from the previous edge.
// Ports:
//   clk      : single clock, rising edge
//   rst      : synchronous active-low reset
//   in_pulse : event strobe, any width; only its rising edge counts
//   en       : measurement enable (low holds timer at 0 and disarms)
//   clr      : synchronous clear of timer, armed flag, FIFO and overflow
//   out_if   : result stream (out_data/out_valid/out_ready, level, overflow)
module pulse_interval_fifo #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_pulse,
  input  logic                  en,
  input  logic                  clr,
  pulse_interval_fifo_if.master out_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] T_MAX    = '1;

  logic             prev;
  logic [CNT_W-1:0] t;
  logic             armed;
  logic [CNT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             overflow;

  logic edge_det;
  logic push_req;
  logic full;
  logic empty;
  logic pop;
  logic push_ok;

  always_comb begin
    edge_det = in_pulse & ~prev;
    push_req = edge_det & en & armed;
    full     = (level == FULL_LVL);
    empty    = (level == '0);
    pop      = ~empty & out_if.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok  = push_req & (~full | pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev     <= 1'b0;
      t        <= '0;
      armed    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      // Edge history keeps tracking even through clr so a held pulse
      // does not look like a fresh edge afterwards.
      prev <= in_pulse;
      if (clr) begin
        t        <= '0;
        armed    <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        overflow <= 1'b0;
      end else begin
        if (!en) begin
          t     <= '0;
          armed <= 1'b0;
        end else if (edge_det) begin
          // t=1 on the cycle after an edge, so t equals the edge distance.
          t     <= CNT_W'(1);
          armed <= 1'b1;
        end else if (t != T_MAX) begin
          t <= t + 1'b1;
        end

        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;

        if (push_ok && !pop)      level <= level + 1'b1;
        else if (!push_ok && pop) level <= level - 1'b1;

        if (push_req && full && !pop) overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: out_valid gates every read.
  always_ff @(posedge clk) begin
    if (rst && !clr && push_ok) mem[wr_ptr] <= t;
  end

  assign out_if.out_valid = ~empty;
  assign out_if.out_data  = empty ? '0 : mem[rd_ptr];
  assign out_if.level     = level;
  assign out_if.overflow  = overflow;
endmodule

// File: tb/tb_pulse_interval_fifo.sv
module tb_pulse_interval_fifo;
  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic in_pulse;
  logic en;
  logic clr;

  pulse_interval_fifo_if #(.CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

  pulse_interval_fifo #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_pulse (in_pulse),
    .en       (en),
    .clr      (clr),
    .out_if   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: timestamps of edges and a plain queue of intervals.
  int mq[$];
  bit m_armed;
  bit m_prev;
  bit m_ovf;
  int m_cyc;
  int m_last;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input bit p, input bit e, input bit c, input bit r, input bit rs);
    bit edge_seen;
    bit do_pop;
    bit do_push;
    int val;
    if (!rs) begin
      m_prev  = 1'b0;
      m_armed = 1'b0;
      m_ovf   = 1'b0;
      mq.delete();
    end else begin
      edge_seen = p && !m_prev;
      do_pop    = (mq.size() > 0) && r;
      if (c) begin
        mq.delete();
        m_armed = 1'b0;
        m_ovf   = 1'b0;
      end else begin
        do_push = edge_seen && e && m_armed;
        val     = m_cyc - m_last;
        if (val > MAXV) val = MAXV;
        if (!e) m_armed = 1'b0;
        else if (edge_seen) begin
          m_armed = 1'b1;
          m_last  = m_cyc;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          if (mq.size() < DEPTH) mq.push_back(val);
          else m_ovf = 1'b1;
        end
      end
      m_prev = p;
    end
    m_cyc++;
  endtask

  // One clock: drive inputs, advance the model, then compare DUT to model.
  task automatic tick(input bit p, input bit e, input bit c, input bit r, input bit rs);
    in_pulse      = p;
    en            = e;
    clr           = c;
    bus.out_ready = r;
    rst           = rs;
    model_step(p, e, c, r, rs);
    @(posedge clk);
    #1;
    chk("model_valid", int'(bus.out_valid), int'(mq.size() != 0));
    chk("model_level", int'(bus.level), mq.size());
    chk("model_ovf", int'(bus.overflow), int'(m_ovf));
    if (mq.size() != 0) chk("model_data", int'(bus.out_data), mq[0]);
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit p;
    bit e;
    bit c;
    bit r;
    bit xv;
    int xd;
    int xl;
    bit xo;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int pdiv_list[6];
    int got[$];

    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 1, 2, 1, 0};
    tbl[3]  = '{0, 1, 0, 0, 1, 2, 1, 0};
    tbl[4]  = '{1, 1, 0, 0, 1, 2, 2, 0};
    tbl[5]  = '{0, 1, 0, 1, 1, 2, 1, 0};
    tbl[6]  = '{0, 1, 0, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 1, 1, 3, 1, 0};
    tbl[8]  = '{1, 1, 0, 0, 1, 3, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 3, 1, 0};
    tbl[10] = '{1, 1, 0, 0, 1, 3, 1, 0};
    tbl[11] = '{0, 1, 0, 0, 1, 3, 1, 0};
    tbl[12] = '{1, 1, 0, 0, 1, 3, 2, 0};
    tbl[13] = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 1, 0, 0, 1, 2, 1, 0};

    in_pulse = 0; en = 0; clr = 0; rst = 0; bus.out_ready = 0;
    m_cyc = 0; m_last = 0; m_armed = 0; m_prev = 0; m_ovf = 0;

    do_reset();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_data", int'(bus.out_data), 0);

    for (int i = 0; i < 17; i++) begin
      tick(tbl[i].p, tbl[i].e, tbl[i].c, tbl[i].r, 1);
      chk($sformatf("vec%0d_valid", i), int'(bus.out_valid), int'(tbl[i].xv));
      chk($sformatf("vec%0d_level", i), int'(bus.level), tbl[i].xl);
      chk($sformatf("vec%0d_ovf", i), int'(bus.overflow), int'(tbl[i].xo));
      if (tbl[i].xv) chk($sformatf("vec%0d_data", i), int'(bus.out_data), tbl[i].xd);
    end

    // Edges at 10, 15, 27: outputs 5 then 12, each visible for one cycle.
    do_reset();
    got.delete();
    for (int k = 0; k < 32; k++) begin
      tick((k == 10 || k == 15 || k == 27), 1, 0, 1, 1);
      chk("seq3_valid", int'(bus.out_valid), int'(k == 15 || k == 27));
      if (bus.out_valid) got.push_back(int'(bus.out_data));
    end
    chk("seq3_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("seq3_first", got[0], 5);
      chk("seq3_second", got[1], 12);
    end

    // Held pulse: one edge only, next edge 40 cycles later pushes 40.
    do_reset();
    got.delete();
    for (int k = 0; k < 46; k++) begin
      tick((k < 30 || k == 40), 1, 0, 1, 1);
      if (bus.out_valid) got.push_back(int'(bus.out_data));
    end
    chk("held_count", got.size(), 1);
    if (got.size() == 1) chk("held_value", got[0], 40);

    // Overflow: six 3-cycle intervals with out_ready low.
    do_reset();
    for (int k = 0; k < 21; k++) begin
      tick((k % 3 == 0 && k <= 18), 1, 0, 0, 1);
      if (k == 12) begin
        chk("ovf_lvl_at4", int'(bus.level), 4);
        chk("ovf_flag_at4", int'(bus.overflow), 0);
      end
      if (k == 15) begin
        chk("ovf_lvl_at5", int'(bus.level), 4);
        chk("ovf_flag_at5", int'(bus.overflow), 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop_data", int'(bus.out_data), 3);
      tick(0, 1, 0, 1, 1);
    end
    chk("ovf_drained", int'(bus.level), 0);
    chk("ovf_sticky", int'(bus.overflow), 1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tick((k % 3 == 0), 1, 0, (k == 15), 1);
      if (k == 12) chk("full_before", int'(bus.level), 4);
    end
    chk("full_pp_level", int'(bus.level), 4);
    chk("full_pp_ovf", int'(bus.overflow), 0);

    // Saturation: 300 cycles between edges reports all-ones.
    do_reset();
    for (int k = 0; k <= 300; k++) tick((k == 0 || k == 300), 1, 0, 0, 1);
    chk("sat_valid", int'(bus.out_valid), 1);
    chk("sat_value", int'(bus.out_data), MAXV);

    // Reset mid-operation, then clr with en low.
    do_reset();
    for (int k = 0; k < 11; k++) tick((k % 3 == 0), 1, 0, 0, 1);
    chk("mid_level3", int'(bus.level), 3);
    tick(0, 1, 0, 0, 0);
    chk("mid_rst_level", int'(bus.level), 0);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_data", int'(bus.out_data), 0);
    for (int k = 0; k < 20; k++) tick((k % 3 == 0 && k <= 18), 1, 0, 0, 1);
    tick(0, 1, 0, 1, 1);
    tick(0, 1, 0, 1, 1);
    chk("clr_pre_level", int'(bus.level), 2);
    chk("clr_pre_ovf", int'(bus.overflow), 1);
    tick(0, 0, 1, 0, 1);
    chk("clr_level", int'(bus.level), 0);
    chk("clr_valid", int'(bus.out_valid), 0);
    chk("clr_ovf", int'(bus.overflow), 0);
    tick(0, 1, 0, 0, 1);
    tick(1, 1, 0, 0, 1);
    chk("clr_first_edge", int'(bus.level), 0);
    tick(0, 1, 0, 0, 1);
    tick(0, 1, 0, 0, 1);
    tick(1, 1, 0, 0, 1);
    chk("clr_second_lvl", int'(bus.level), 1);
    chk("clr_second_val", int'(bus.out_data), 3);

    // Randomized phase against the reference model.
    pdiv_list[0] = 2; pdiv_list[1] = 4; pdiv_list[2] = 8;
    pdiv_list[3] = 40; pdiv_list[4] = 300; pdiv_list[5] = 3;
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 500; k++) begin
        tick(($urandom_range(0, pdiv_list[b] - 1) == 0),
             ($urandom_range(0, 29) != 0),
             ($urandom_range(0, 99) == 0),
             (b % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 199) != 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pulse_interval_fifo.md
PULSE_INTERVAL_FIFO -- requirements
Module: pulse_interval_fifo

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the interval width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the FIFO entry count (power of two, 2 minimum).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 in_pulse  input  1  event strobe from the upstream counter's out_pulse, any width in cycles.
REQ-006 en  input  1  measurement enable.
REQ-007 clr  input  1  synchronous clear of measurement state, FIFO and flags.
REQ-008 out_data  output  CNT_W  interval at the FIFO head.
REQ-009 out_valid  output  1  FIFO not empty.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  output  1  sticky flag for a dropped measurement.

Function
REQ-013 Edge detect: the block SHALL keep a registered copy prev of in_pulse; edge = in_pulse & ~prev, in the same cycle; a pulse held high SHALL produce one edge only.
REQ-014 Timer t (CNT_W bits): on an edge with en=1, t SHALL load 1; otherwise, with en=1, t <= t+1, saturating at 2^CNT_W-1 (no wrap).
REQ-015 Armed flag: the first edge after reset, clr or en rising SHALL set armed and SHALL NOT push.
REQ-016 Each later edge with en=1 and armed=1 SHALL push the current t (the cycle distance from the previous edge).
REQ-017 Example: edges in cycles 0 and 5 push 5.
REQ-018 A saturated value of all-ones SHALL mean an interval of at least 2^CNT_W-1 cycles.
REQ-019 en=0 SHALL hold t at 0, clear armed and ignore edges; prev SHALL still track in_pulse; FIFO pops SHALL continue.
REQ-020 FIFO: first-word-fall-through; out_data SHALL be valid whenever out_valid=1.
REQ-021 Pushed data SHALL appear on out_valid/out_data in the cycle after the edge (latency 1).
REQ-022 Pop SHALL occur when out_valid & out_ready.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL be held stable.
REQ-024 Push and pop in the same cycle SHALL both occur and leave level unchanged, including when full and when level=1.
REQ-025 A push when level=DEPTH and no pop SHALL drop the new value, leave FIFO contents unchanged and set overflow.
REQ-026 overflow SHALL stay set until clr or reset.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 level SHALL never exceed DEPTH or underflow.
REQ-029 out_ready with out_valid=0 SHALL have no effect.
REQ-030 clr=1 SHALL, in the next cycle, empty the FIFO and clear t, armed and overflow.
REQ-031 clr SHALL take priority over a simultaneous push and pop; prev SHALL still update.

Reset
REQ-032 While rst=0 at a clock edge, the block SHALL set t=0, armed=0, prev=0, pointers=0, level=0, out_valid=0, overflow=0 and out_data=0.
REQ-033 Reset SHALL take priority over clr and en.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries and any partial interval.
REQ-035 After reset, the first edge SHALL be treated as unarmed.

Verification
REQ-036 Edges in cycles 10, 15 and 27, en=1, out_ready=1 -> exactly two outputs, 5 then 12; each out_valid=1 for one cycle, in the cycle after its edge.
REQ-037 in_pulse held high 30 cycles, then low, then an edge 40 cycles after the first -> one pushed value of 40; no extra edge while held high.
REQ-038 out_ready=0, 6 intervals of 3 cycles each, DEPTH=4 -> level=4, overflow=1 after the 5th push, and 4 pops return 3,3,3,3.
REQ-039 FIFO full, out_ready=1 held, edge arrives -> push and pop in the same cycle, level stays 4, overflow stays 0.
REQ-040 No edge for 300 cycles after armed, CNT_W=8 -> pushed value 255.
REQ-041 rst=0 for one cycle with level=3, then clr tested with level=2 and en toggled low -> level=0, out_valid=0, overflow=0, and the next edge is not pushed.
